// File: rtl/beta_trap_pkg.sv
// rtl/beta_trap_pkg.sv - shared trap codes, causes and TCU state encoding
package beta_trap_pkg;

  typedef enum logic [1:0] {
    INSTR_NOTRAP        = 2'd0,
    INSTR_MISALIG_FETCH = 2'd1,
    INSTR_ILLEGAL_FETCH = 2'd2
  } instr_trap_e;

  typedef enum logic [1:0] {
    LSU_NOTRAP        = 2'd0,
    LSU_MISALIG_LOAD  = 2'd1,
    LSU_MISALIG_STORE = 2'd2
  } lsu_trap_e;

  typedef enum logic [1:0] {
    TCU_NOTRAP    = 2'd0,
    TCU_INTERRUPT = 2'd1,
    TCU_EXCEPTION = 2'd2
  } tcu_trap_e;

  // bit 4 marks an interrupt; bits 3:0 are the architectural cause code
  typedef enum logic [4:0] {
    INSTR_ADDR_MISALIGNED = 5'h00,
    INSTR_ILLEGAL         = 5'h02,
    LOAD_ADDR_MISALIGNED  = 5'h04,
    STORE_ADDR_MISALIGNED = 5'h06,
    MSW_INT               = 5'h13,
    MTIM_INT              = 5'h17,
    MEXT_INT              = 5'h1B
  } trap_cause_e;

  typedef enum logic [2:0] {
    TCU_IDLE     = 3'd0,
    TCU_FLUSH    = 3'd1,
    TCU_UPDATE   = 3'd2,
    TCU_REDIRECT = 3'd3,
    TCU_RETURN   = 3'd4
  } tcu_state_e;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  function automatic logic [31:0] cause_to_mcause(input trap_cause_e c);
    return {c[4], 27'b0, c[3:0]};
  endfunction

endpackage

// File: rtl/beta_irq_sync.sv
// rtl/beta_irq_sync.sv - SYNC_STAGES-deep synchroniser for the three M-mode irq lines
module beta_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] irq_i,
  output logic [2:0] irq_o
);

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign irq_o = irq_i;
    end else begin : g_sync
      logic [2:0] stage_q [SYNC_STAGES];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            stage_q[i] <= 3'b0;
          end
        end else begin
          stage_q[0] <= irq_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign irq_o = stage_q[SYNC_STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/beta_tcu.sv
// rtl/beta_tcu.sv - trap control unit: arbitrates one trap or MRET, flushes,
// strobes the CSR update and redirects fetch to the handler
module beta_tcu
  import beta_trap_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_valid_i,
  input  logic [1:0]  instr_trap_i,
  input  logic [31:0] instr_pc_i,
  input  logic [31:0] instr_word_i,
  input  logic [31:0] next_pc_i,
  input  logic [1:0]  lsu_trap_i,
  input  logic [31:0] lsu_pc_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        irq_msw_i,
  input  logic        irq_mtim_i,
  input  logic        irq_mext_i,
  input  logic        mstatus_mie_i,
  input  logic [2:0]  mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic        mret_i,
  output logic [1:0]  tcu_trap_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        csr_we_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic        mret_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  tcu_state_e  state_q, state_d;
  tcu_trap_e   kind_q;
  trap_cause_e cause_q;
  logic [31:0] mepc_q, mtval_q, rpc_q;

  // ordered like mie_i: {MEIE, MTIE, MSIE}
  logic [2:0] irq_sync, irq_pend;

  beta_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .irq_i ({irq_mext_i, irq_mtim_i, irq_msw_i}),
    .irq_o (irq_sync)
  );

  assign irq_pend = mstatus_mie_i ? (irq_sync & mie_i) : 3'b000;

  logic        take_trap;
  tcu_trap_e   sel_kind;
  trap_cause_e sel_cause;
  logic [31:0] sel_epc, sel_tval, trap_base, sel_target;
  logic        use_vector;

  always_comb begin
    take_trap = 1'b0;
    sel_kind  = TCU_NOTRAP;
    sel_cause = INSTR_ADDR_MISALIGNED;
    sel_epc   = 32'h0;
    sel_tval  = 32'h0;
    if (lsu_trap_i == LSU_MISALIG_LOAD || lsu_trap_i == LSU_MISALIG_STORE) begin
      take_trap = 1'b1;
      sel_kind  = TCU_EXCEPTION;
      sel_cause = (lsu_trap_i == LSU_MISALIG_LOAD) ? LOAD_ADDR_MISALIGNED : STORE_ADDR_MISALIGNED;
      sel_epc   = lsu_pc_i;
      sel_tval  = lsu_addr_i;
    end else if (instr_valid_i && instr_trap_i == INSTR_MISALIG_FETCH) begin
      take_trap = 1'b1;
      sel_kind  = TCU_EXCEPTION;
      sel_cause = INSTR_ADDR_MISALIGNED;
      sel_epc   = instr_pc_i;
      sel_tval  = instr_pc_i;
    end else if (instr_valid_i && instr_trap_i == INSTR_ILLEGAL_FETCH) begin
      take_trap = 1'b1;
      sel_kind  = TCU_EXCEPTION;
      sel_cause = INSTR_ILLEGAL;
      sel_epc   = instr_pc_i;
      sel_tval  = instr_word_i;
    end else if (instr_valid_i && irq_pend != 3'b000) begin
      take_trap = 1'b1;
      sel_kind  = TCU_INTERRUPT;
      sel_cause = irq_pend[2] ? MEXT_INT : (irq_pend[0] ? MSW_INT : MTIM_INT);
      sel_epc   = next_pc_i;
    end
  end

  // reserved MODE encodings (>=2) fall back to direct
  assign trap_base  = {mtvec_i[31:2], 2'b00};
  assign use_vector = VECTORED_EN && (sel_kind == TCU_INTERRUPT) &&
                      (mtvec_i[1:0] == MTVEC_VECTORED);
  assign sel_target = use_vector ? (trap_base + {26'b0, sel_cause[3:0], 2'b00}) : trap_base;

  logic load_trap, load_mret;

  always_comb begin
    state_d       = state_q;
    load_trap     = 1'b0;
    load_mret     = 1'b0;
    stall_o       = 1'b0;
    flush_o       = 1'b0;
    csr_we_o      = 1'b0;
    redirect_o    = 1'b0;
    mret_o        = 1'b0;
    case (state_q)
      TCU_IDLE: begin
        if (take_trap) begin
          load_trap = 1'b1;
          state_d   = TCU_FLUSH;
        end else if (mret_i) begin
          load_mret = 1'b1;
          state_d   = TCU_RETURN;
        end
      end
      TCU_FLUSH: begin
        stall_o = 1'b1;
        flush_o = 1'b1;
        state_d = TCU_UPDATE;
      end
      TCU_UPDATE: begin
        stall_o  = 1'b1;
        csr_we_o = 1'b1;
        state_d  = TCU_REDIRECT;
      end
      TCU_REDIRECT: begin
        stall_o    = 1'b1;
        redirect_o = 1'b1;
        state_d    = TCU_IDLE;
      end
      TCU_RETURN: begin
        stall_o    = 1'b1;
        flush_o    = 1'b1;
        mret_o     = 1'b1;
        redirect_o = 1'b1;
        state_d    = TCU_IDLE;
      end
      default: state_d = TCU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= TCU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // trap record is captured in the arbitration cycle and held until the next trap
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      kind_q  <= TCU_NOTRAP;
      cause_q <= INSTR_ADDR_MISALIGNED;
      mepc_q  <= 32'h0;
      mtval_q <= 32'h0;
      rpc_q   <= 32'h0;
    end else if (load_trap) begin
      kind_q  <= sel_kind;
      cause_q <= sel_cause;
      mepc_q  <= {sel_epc[31:2], 2'b00};
      mtval_q <= sel_tval;
      rpc_q   <= sel_target;
    end else if (load_mret) begin
      rpc_q   <= mepc_i;
    end
  end

  assign tcu_trap_o    = (state_q == TCU_FLUSH || state_q == TCU_UPDATE ||
                          state_q == TCU_REDIRECT) ? kind_q : TCU_NOTRAP;
  assign mcause_o      = cause_to_mcause(cause_q);
  assign mepc_o        = mepc_q;
  assign mtval_o       = mtval_q;
  assign redirect_pc_o = rpc_q;

endmodule

// File: tb/tb_beta_tcu.sv
// tb/tb_beta_tcu.sv - directed bench for beta_tcu with a cycle-timeline reference model
module tb_beta_tcu;
  import beta_trap_pkg::*;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid;
  logic [1:0]  instr_trap;
  logic [31:0] instr_pc, instr_word, next_pc;
  logic [1:0]  lsu_trap;
  logic [31:0] lsu_pc, lsu_addr;
  logic        irq_msw, irq_mtim, irq_mext, mstatus_mie;
  logic [2:0]  mie;
  logic [31:0] mtvec, mepc_in;
  logic        mret_in;
  logic [1:0]  tcu_trap;
  logic        stall, flush, csr_we, mret_out, redirect;
  logic [31:0] mcause, mepc_out, mtval, redirect_pc;

  beta_tcu #(.SYNC_STAGES(SYNC), .VECTORED_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(instr_valid), .instr_trap_i(instr_trap),
    .instr_pc_i(instr_pc), .instr_word_i(instr_word), .next_pc_i(next_pc),
    .lsu_trap_i(lsu_trap), .lsu_pc_i(lsu_pc), .lsu_addr_i(lsu_addr),
    .irq_msw_i(irq_msw), .irq_mtim_i(irq_mtim), .irq_mext_i(irq_mext),
    .mstatus_mie_i(mstatus_mie), .mie_i(mie), .mtvec_i(mtvec), .mepc_i(mepc_in),
    .mret_i(mret_in),
    .tcu_trap_o(tcu_trap), .stall_o(stall), .flush_o(flush), .csr_we_o(csr_we),
    .mcause_o(mcause), .mepc_o(mepc_out), .mtval_o(mtval), .mret_o(mret_out),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  // expected strobe pattern for one cycle
  typedef struct packed {
    bit       stall;
    bit       flush;
    bit       csr_we;
    bit       redirect;
    bit       mret;
    bit [1:0] trap;
  } exp_t;

  exp_t        cur = '0;
  exp_t        pend[$];
  logic [31:0] e_mcause = 0, e_mepc = 0, e_mtval = 0, e_rpc = 0;
  logic [2:0]  hist [SYNC];

  task automatic model_arbitrate(input logic [2:0] seen);
    bit          hit;
    logic [1:0]  kind;
    logic [31:0] cause, epc, tval, base;
    logic [2:0]  p;
    int          code;
    hit  = 0; kind = 0; cause = 0; epc = 0; tval = 0; code = 0;
    p    = mstatus_mie ? (seen & mie) : 3'b000;
    base = {mtvec[31:2], 2'b00};
    if (lsu_trap == 2'd1 || lsu_trap == 2'd2) begin
      hit = 1; kind = 2; cause = (lsu_trap == 2'd1) ? 4 : 6; epc = lsu_pc; tval = lsu_addr;
    end else if (instr_valid && instr_trap == 2'd1) begin
      hit = 1; kind = 2; cause = 0; epc = instr_pc; tval = instr_pc;
    end else if (instr_valid && instr_trap == 2'd2) begin
      hit = 1; kind = 2; cause = 2; epc = instr_pc; tval = instr_word;
    end else if (instr_valid && p != 3'b000) begin
      code = p[2] ? 11 : (p[0] ? 3 : 7);
      hit = 1; kind = 1; cause = 32'h8000_0000 | code; epc = next_pc; tval = 0;
    end
    if (hit) begin
      e_mcause = cause;
      e_mepc   = epc & ~32'h3;
      e_mtval  = tval;
      e_rpc    = (kind == 1 && mtvec[1:0] == 2'b01) ? base + 32'(code * 4) : base;
      cur      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, kind};
      pend.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, kind});
      pend.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, kind});
    end else if (mret_in) begin
      e_rpc = mepc_in;
      cur   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    end
  endtask

  always @(posedge clk) begin
    logic [2:0] seen;
    if (rst) begin
      cur = '0;
      pend.delete();
      e_mcause = 0; e_mepc = 0; e_mtval = 0; e_rpc = 0;
      for (int i = 0; i < SYNC; i++) hist[i] = 3'b000;
    end else begin
      seen = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {irq_mext, irq_mtim, irq_msw};
      if (cur.stall) begin
        if (pend.size() > 0) cur = pend.pop_front();
        else cur = '0;
      end else begin
        model_arbitrate(seen);
      end
    end
  end

  always @(negedge clk) begin
    if ($time > 1) begin
      chk("stall", 32'(stall), 32'(cur.stall));
      chk("flush", 32'(flush), 32'(cur.flush));
      chk("csr_we", 32'(csr_we), 32'(cur.csr_we));
      chk("redirect", 32'(redirect), 32'(cur.redirect));
      chk("mret", 32'(mret_out), 32'(cur.mret));
      chk("tcu_trap", 32'(tcu_trap), 32'(cur.trap));
      chk("mcause", mcause, e_mcause);
      chk("mepc", mepc_out, e_mepc);
      chk("mtval", mtval, e_mtval);
      chk("redirect_pc", redirect_pc, e_rpc);
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    instr_valid = 0; instr_trap = INSTR_NOTRAP; instr_pc = 0; instr_word = 0; next_pc = 0;
    lsu_trap = LSU_NOTRAP; lsu_pc = 0; lsu_addr = 0;
    irq_msw = 0; irq_mtim = 0; irq_mext = 0; mstatus_mie = 0; mie = 0;
    mtvec = 0; mepc_in = 0; mret_in = 0;
  endtask

  task automatic wait_flush(input string name, output int cycles);
    cycles = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (flush) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) chk(name, 32'(flush), 32'd1);
  endtask

  initial begin
    int n;
    for (int i = 0; i < SYNC; i++) hist[i] = 3'b000;
    clear_inputs();
    #1 rst = 1;
    step(); step();
    chk("rst_stall", 32'(stall), 0);
    chk("rst_trap", 32'(tcu_trap), 0);
    chk("rst_rpc", redirect_pc, 0);
    rst = 0;
    step();

    // misaligned load
    lsu_trap = LSU_MISALIG_LOAD; lsu_pc = 32'h100; lsu_addr = 32'h2003; mtvec = 32'h8000;
    step();
    lsu_trap = LSU_NOTRAP;
    chk("ld_flush", 32'(flush), 1);
    chk("ld_mcause", mcause, 32'h4);
    step();
    chk("ld_csr_we", 32'(csr_we), 1);
    chk("ld_mepc", mepc_out, 32'h100);
    chk("ld_mtval", mtval, 32'h2003);
    step();
    chk("ld_redirect", 32'(redirect), 1);
    chk("ld_rpc", redirect_pc, 32'h8000);
    step();
    chk("ld_idle", 32'(stall), 0);

    // LSU store beats simultaneous illegal instruction
    instr_valid = 1; instr_trap = INSTR_ILLEGAL_FETCH; instr_pc = 32'h104; instr_word = 32'h0000_FFFF;
    lsu_trap = LSU_MISALIG_STORE; lsu_pc = 32'h100; lsu_addr = 32'h3001;
    step();
    clear_inputs(); mtvec = 32'h8000;
    chk("st_mcause", mcause, 32'h6);
    chk("st_mepc", mepc_out, 32'h100);
    chk("st_mtval", mtval, 32'h3001);
    repeat (4) step();

    // MEXT + MTIM pending, vectored mtvec
    irq_mext = 1; irq_mtim = 1; mstatus_mie = 1; mie = 3'b111; instr_valid = 1;
    mtvec = 32'h8001; next_pc = 32'h200;
    wait_flush("ext_taken", n);
    irq_mext = 0; irq_mtim = 0;
    chk("ext_mcause", mcause, 32'h8000_000B);
    chk("ext_mepc", mepc_out, 32'h200);
    chk("ext_mtval", mtval, 32'h0);
    step(); step();
    chk("ext_rpc", redirect_pc, 32'h802C);
    chk("ext_trap", 32'(tcu_trap), 32'(TCU_INTERRUPT));
    clear_inputs();
    repeat (4) step();

    // global MIE off: no interrupt
    irq_mext = 1; mie = 3'b111; mstatus_mie = 0; instr_valid = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mie_off_stall", 32'(stall), 0);
    end
    clear_inputs();
    repeat (3) step();

    // MRET
    mret_in = 1; mepc_in = 32'h340;
    step();
    clear_inputs();
    chk("mret_mret", 32'(mret_out), 1);
    chk("mret_redirect", 32'(redirect), 1);
    chk("mret_flush", 32'(flush), 1);
    chk("mret_rpc", redirect_pc, 32'h340);
    step();
    chk("mret_done", 32'(stall), 0);

    // MRET loses to illegal instruction
    mret_in = 1; mepc_in = 32'h340; instr_valid = 1; instr_trap = INSTR_ILLEGAL_FETCH;
    instr_pc = 32'h104; instr_word = 32'hDEAD_BEEF; mtvec = 32'h8000;
    step();
    clear_inputs();
    chk("mx_mret", 32'(mret_out), 0);
    chk("mx_mcause", mcause, 32'h2);
    chk("mx_mtval", mtval, 32'hDEAD_BEEF);
    repeat (4) step();

    // misaligned fetch: vectored mtvec ignored for exceptions, mepc low bits cleared
    instr_valid = 1; instr_trap = INSTR_MISALIG_FETCH; instr_pc = 32'h206; mtvec = 32'h9001;
    step();
    clear_inputs();
    chk("mf_mepc", mepc_out, 32'h204);
    chk("mf_mtval", mtval, 32'h206);
    chk("mf_rpc", redirect_pc, 32'h9000);
    repeat (4) step();

    // reserved trap codes are no trap
    instr_valid = 1; instr_trap = 2'b11; lsu_trap = 2'b11;
    step(); step();
    chk("rsv_stall", 32'(stall), 0);
    clear_inputs();

    // interrupt waits for an instruction boundary
    irq_msw = 1; mstatus_mie = 1; mie = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("noinst_stall", 32'(stall), 0);
    end
    clear_inputs();
    repeat (4) step();

    // MSW through the 2-stage synchroniser
    irq_msw = 1; mstatus_mie = 1; mie = 3'b111; instr_valid = 1; mtvec = 32'h8001; next_pc = 32'h400;
    wait_flush("msw_taken", n);
    irq_msw = 0;
    chk("msw_latency", 32'(n), 32'd3);
    chk("msw_mcause", mcause, 32'h8000_0003);
    chk("msw_rpc", redirect_pc, 32'h800C);
    clear_inputs();
    repeat (5) step();

    // MTIM with vectored target wrapping past 2^32
    irq_mtim = 1; mstatus_mie = 1; mie = 3'b010; instr_valid = 1; mtvec = 32'hFFFF_FFF1; next_pc = 32'h502;
    wait_flush("tim_taken", n);
    irq_mtim = 0;
    chk("tim_mcause", mcause, 32'h8000_0007);
    chk("tim_mepc", mepc_out, 32'h500);
    chk("tim_rpc", redirect_pc, 32'h0000_000C);
    clear_inputs();
    repeat (5) step();

    // reset pulsed during UPDATE
    lsu_trap = LSU_MISALIG_LOAD; lsu_pc = 32'h100; lsu_addr = 32'h2003; mtvec = 32'h8000;
    step();
    clear_inputs();
    step();
    chk("rm_csr_we_before", 32'(csr_we), 1);
    rst = 1;
    #1;
    chk("rm_csr_we", 32'(csr_we), 0);
    chk("rm_stall", 32'(stall), 0);
    chk("rm_mcause", mcause, 0);
    chk("rm_rpc", redirect_pc, 0);
    step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rm_no_csr_we", 32'(csr_we), 0);
      chk("rm_no_redirect", 32'(redirect), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

endmodule
